// File: rtl/matrix_digit_renderer.sv
// matrix_digit_renderer: ROWS x COLS matrix of unsigned values drawn as right-aligned decimal text on a VGA raster
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   clk_en              pixel-rate enable; advances the two-stage pixel pipeline
//   wr_valid, wr_ready  write handshake; one value accepted per VAL_W+2 clocks
//   wr_row, wr_col      target cell; out-of-range targets complete the handshake but store nothing
//   wr_data             unsigned value, saturated to all nines when it needs more than DIGITS digits
//   h_count, v_count    raster position presented to the pipeline
//   pixon, vga_rgb      lit glyph pixel and its colour, two clk_en pulses after the position
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits of each cell.
module matrix_digit_renderer #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int DIGITS = 3,
    parameter int VAL_W = 10,
    parameter int X0 = 100,
    parameter int Y0 = 50,
    parameter int COL_PITCH = 100,
    parameter int ROW_PITCH = 20,
    parameter logic [11:0] FG_RGB = 12'hFFF
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  clk_en,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] wr_row,
    input  logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0] wr_col,
    input  logic [VAL_W-1:0]                      wr_data,
    input  logic [10:0]                           h_count,
    input  logic [10:0]                           v_count,
    output logic                                  pixon,
    output logic [11:0]                           vga_rgb
);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int BW = 4 * DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam int NCD = ROWS * COLS * DIGITS;

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    localparam int MAXV = pow10(DIGITS) - 1;

    // Double-dabble correction step: every BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] o;
        o = b;
        for (int k = 0; k < DIGITS; k++)
            o[4*k +: 4] = b[4*k +: 4] >= 4'd5 ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
        return o;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Bit k (k=0 most significant digit) is set while digits 0..k are all zero; the last digit never blanks.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] b);
        logic [DIGITS-1:0] m;
        logic z;
        z = 1'b1;
        m = '0;
        for (int k = 0; k < DIGITS - 1; k++) begin
            z = z & (b[4*(DIGITS-1-k) +: 4] == 4'd0);
            m[k] = z;
        end
        return m;
    endfunction
`endif

    // 8x16 glyphs, row 0 in the top byte, bit 7 of each byte is the leftmost pixel.
    function automatic logic [127:0] font_glyph(input logic [3:0] n);
        case (n)
            4'd0:    return 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            4'd1:    return 128'h00001838781818181818187E00000000;
            4'd2:    return 128'h00007CC6060C183060C0C6FE00000000;
            4'd3:    return 128'h00007CC606063C060606C67C00000000;
            4'd4:    return 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            4'd5:    return 128'h0000FEC0C0C0FC060606C67C00000000;
            4'd6:    return 128'h00003860C0C0FCC6C6C6C67C00000000;
            4'd7:    return 128'h0000FEC606060C183030303000000000;
            4'd8:    return 128'h00007CC6C6C67CC6C6C6C67C00000000;
            4'd9:    return 128'h00007CC6C6C67E0606060C7800000000;
            default: return 128'h0;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t           st;
    logic [RW-1:0]    lat_row;
    logic [CW-1:0]    lat_col;
    logic [VAL_W-1:0] lat_data;
    logic [VAL_W-1:0] sh;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    commit_bcd;
    logic [CNT_W-1:0] cnt;

    assign bcd_adj = dd_adjust(bcd);
    // Oversized values lose their top BCD digits in the engine, so saturate from the latched binary value.
    assign commit_bcd = 32'(lat_data) > MAXV ? {DIGITS{4'h9}} : bcd;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st <= IDLE;
            wr_ready <= 1'b1;
            cnt <= '0;
            lat_row <= '0;
            lat_col <= '0;
            lat_data <= '0;
            sh <= '0;
            bcd <= '0;
        end else begin
            case (st)
                IDLE: if (wr_valid && wr_ready) begin
                    lat_row <= wr_row;
                    lat_col <= wr_col;
                    lat_data <= wr_data;
                    sh <= wr_data;
                    bcd <= '0;
                    cnt <= '0;
                    st <= CONV;
                    wr_ready <= 1'b0;
                end
                CONV: begin
                    bcd <= {bcd_adj[BW-2:0], sh[VAL_W-1]};
                    sh <= sh << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(VAL_W - 1)) st <= COMMIT;
                end
                COMMIT: begin
                    st <= IDLE;
                    wr_ready <= 1'b1;
                end
                default: st <= IDLE;
            endcase
        end
    end

    int hx;
    int vy;
    assign hx = 32'(h_count);
    assign vy = 32'(v_count);

    logic [NCD-1:0]   hit_v;
    logic [NCD-1:0]   bl_v;
    logic [4*NCD-1:0] nib_v;
    logic [3*NCD-1:0] gx_v;
    logic [4*NCD-1:0] gy_v;

    // Each cell owns its storage; a target outside the matrix matches no cell, so COMMIT writes nothing.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [BW-1:0] q;
`ifdef LEADING_ZERO_BLANK_EN
            logic [DIGITS-1:0] bm;
`endif
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    q <= '0;
`ifdef LEADING_ZERO_BLANK_EN
                    bm <= blank_mask(BW'(0));
`endif
                end else if (st == COMMIT && lat_row == RW'(r) && lat_col == CW'(c)) begin
                    q <= commit_bcd;
`ifdef LEADING_ZERO_BLANK_EN
                    bm <= blank_mask(commit_bcd);
`endif
                end
            end
            for (genvar d = 0; d < DIGITS; d++) begin : g_dig
                localparam int K = (r * COLS + c) * DIGITS + d;
                localparam int XS = X0 + c * COL_PITCH + 8 * d;
                localparam int YS = Y0 + r * ROW_PITCH;
                assign hit_v[K] = hx >= XS && hx < XS + 8 && vy >= YS && vy < YS + 16;
                assign nib_v[4*K +: 4] = q[4*(DIGITS-1-d) +: 4];
                assign gx_v[3*K +: 3] = 3'(hx - XS);
                assign gy_v[4*K +: 4] = 4'(vy - YS);
`ifdef LEADING_ZERO_BLANK_EN
                assign bl_v[K] = bm[d];
`else
                assign bl_v[K] = 1'b0;
`endif
            end
        end
    end

    logic       hit_c;
    logic       bl_c;
    logic [3:0] nib_c;
    logic [2:0] gx_c;
    logic [3:0] gy_c;

    // Digit regions never overlap, so at most one hit term is live and an OR merges the selections.
    always_comb begin
        hit_c = |hit_v;
        bl_c = |(bl_v & hit_v);
        nib_c = '0;
        gx_c = '0;
        gy_c = '0;
        for (int k = 0; k < NCD; k++) begin
            nib_c = nib_c | (nib_v[4*k +: 4] & {4{hit_v[k]}});
            gx_c = gx_c | (gx_v[3*k +: 3] & {3{hit_v[k]}});
            gy_c = gy_c | (gy_v[4*k +: 4] & {4{hit_v[k]}});
        end
    end

    logic       s1_valid;
    logic       s1_hit;
    logic [3:0] s1_nib;
    logic [2:0] s1_gx;
    logic [3:0] s1_gy;
    logic [7:0] glyph_row;
    logic       pix_c;

    // Shifting by 8*(15-gy) brings glyph row gy into the low byte.
    assign glyph_row = 8'(font_glyph(s1_nib) >> {~s1_gy, 3'b000});
    assign pix_c = s1_valid & s1_hit & glyph_row[~s1_gx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_hit <= 1'b0;
            s1_nib <= '0;
            s1_gx <= '0;
            s1_gy <= '0;
            pixon <= 1'b0;
            vga_rgb <= '0;
        end else if (clk_en) begin
            s1_valid <= 1'b1;
            s1_hit <= hit_c & ~bl_c;
            s1_nib <= nib_c;
            s1_gx <= gx_c;
            s1_gy <= gy_c;
            pixon <= pix_c;
            vga_rgb <= pix_c ? FG_RGB : 12'h000;
        end
    end
endmodule

// File: tb/tb_matrix_digit_renderer.sv
// tb_matrix_digit_renderer: directed checks of writes, saturation, throughput, reset abort and pixel timing
module tb_matrix_digit_renderer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_row = '0;
    logic [1:0]  wr_col = '0;
    logic [9:0]  wr_data = '0;
    logic [10:0] h_count = '0;
    logic [10:0] v_count = '0;
    logic        pixon;
    logic [11:0] vga_rgb;

    int n_chk = 0;
    int n_fail = 0;
    int val [3][3];

    matrix_digit_renderer dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .h_count(h_count), .v_count(v_count),
        .pixon(pixon), .vga_rgb(vga_rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] glyph(input int n);
        case (n)
            0: return 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            1: return 128'h00001838781818181818187E00000000;
            2: return 128'h00007CC6060C183060C0C6FE00000000;
            3: return 128'h00007CC606063C060606C67C00000000;
            4: return 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            5: return 128'h0000FEC0C0C0FC060606C67C00000000;
            6: return 128'h00003860C0C0FCC6C6C6C67C00000000;
            7: return 128'h0000FEC606060C183030303000000000;
            8: return 128'h00007CC6C6C67CC6C6C6C67C00000000;
            9: return 128'h00007CC6C6C67E0606060C7800000000;
            default: return 128'h0;
        endcase
    endfunction

    function automatic int digit_of(input int value, input int d);
        return d == 0 ? value / 100 : d == 1 ? (value / 10) % 10 : value % 10;
    endfunction

    function automatic bit blank_of(input int value, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d == 0 && value < 100) || (d == 1 && value < 10);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_pix(input int h, input int v);
        logic [127:0] g;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int d = 0; d < 3; d++) begin
                    int xs, ys;
                    xs = 100 + 100 * c + 8 * d;
                    ys = 50 + 20 * r;
                    if (h >= xs && h < xs + 8 && v >= ys && v < ys + 16) begin
                        g = glyph(digit_of(val[r][c], d));
                        return blank_of(val[r][c], d) ? 1'b0 : g[127 - 8 * (v - ys) - (h - xs)];
                    end
                end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Streams n pixels of one line; bit n-1 of the result is the leftmost pixel.
    task automatic sample_row(input int h0, input int v, input int n, output logic [255:0] bits);
        bits = '0;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                h_count = 11'(h0 + i);
                v_count = 11'(v);
            end
            tick;
            if (i > 0) bits[n - i] = pixon;
        end
    endtask

    task automatic scan(input string tag);
        logic [255:0] act, exp;
        for (int v = 40; v <= 115; v++) begin
            sample_row(90, v, 241, act);
            exp = '0;
            for (int i = 0; i < 241; i++) exp[240 - i] = exp_pix(90 + i, v);
            check($sformatf("%s_line%0d", tag, v), act, exp);
        end
    endtask

    task automatic check_cell(input int r, input int c);
        logic [255:0] act, exp;
        logic [127:0] g;
        int value;
        value = val[r][c];
        for (int d = 0; d < 3; d++) begin
            g = glyph(digit_of(value, d));
            for (int y = 0; y < 16; y++) begin
                sample_row(100 + 100 * c + 8 * d, 50 + 20 * r + y, 8, act);
                exp = '0;
                if (!blank_of(value, d)) exp[7:0] = g[127 - 8 * y -: 8];
                check($sformatf("cell%0d%0d_d%0d_row%0d", r, c, d, y), act, exp);
            end
        end
    endtask

    task automatic write_cell(input int r, input int c, input int data);
        int k;
        k = 0;
        while (!wr_ready && k < 100) begin
            tick;
            k++;
        end
        check("wr_ready_idle", wr_ready, 1);
        wr_row = 2'(r);
        wr_col = 2'(c);
        wr_data = 10'(data);
        wr_valid = 1'b1;
        tick;
        wr_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("wr_ready_busy%0d", i), wr_ready, 0);
            tick;
        end
        check("wr_ready_back", wr_ready, 1);
        if (r < 3 && c < 3) val[r][c] = data > 999 ? 999 : data;
    endtask

    initial begin
        int gap;
        foreach (val[r, c]) val[r][c] = 0;
        repeat (3) tick;
        check("rst_pixon", pixon, 0);
        check("rst_rgb", vga_rgb, 0);
        reset_n = 1'b1;
        check("rst_ready", wr_ready, 1);
        tick;
        check("rst_ready_next", wr_ready, 1);
        scan("reset");

        write_cell(1, 2, 123);
        check_cell(1, 2);
        write_cell(0, 0, 1023);
        check_cell(0, 0);

        wr_valid = 1'b1;
        wr_row = 2'd2;
        wr_col = 2'd0;
        wr_data = 10'd5;
        check("b2b_ready", wr_ready, 1);
        tick;
        for (int w = 1; w < 3; w++) begin
            wr_col = 2'(w);
            wr_data = w == 1 ? 10'd78 : 10'd640;
            gap = 1;
            while (!wr_ready && gap < 100) begin
                tick;
                gap++;
            end
            check($sformatf("b2b_interval%0d", w), gap, 12);
            tick;
        end
        wr_valid = 1'b0;
        gap = 0;
        while (!wr_ready && gap < 100) begin
            tick;
            gap++;
        end
        check("b2b_done", wr_ready, 1);
        val[2][0] = 5;
        val[2][1] = 78;
        val[2][2] = 640;
        check_cell(2, 0);
        check_cell(2, 1);
        check_cell(2, 2);

        write_cell(3, 0, 77);
        write_cell(0, 1, 7);
        scan("final");

        while (!wr_ready) tick;
        wr_row = 2'd0;
        wr_col = 2'd0;
        wr_data = 10'd456;
        wr_valid = 1'b1;
        tick;
        wr_valid = 1'b0;
        repeat (4) tick;
        check("conv_busy", wr_ready, 0);
        reset_n = 1'b0;
        tick;
        tick;
        check("midrst_pixon", pixon, 0);
        check("midrst_rgb", vga_rgb, 0);
        reset_n = 1'b1;
        check("midrst_ready", wr_ready, 1);
        foreach (val[r, c]) val[r][c] = 0;
        repeat (12) tick;
        check("midrst_ready_hold", wr_ready, 1);
        check_cell(0, 0);
        check_cell(1, 2);

        h_count = 11'd115;
        v_count = 11'd55;
        tick;
        tick;
        check("edge_off", pixon, 0);
        clk_en = 1'b0;
        h_count = 11'd116;
        for (int s = 0; s < 3; s++) begin
            clk_en = 1'b1;
            tick;
            clk_en = 1'b0;
            check($sformatf("edge_slot%0d_pix", s), pixon, s >= 1);
            check($sformatf("edge_slot%0d_rgb", s), vga_rgb, s >= 1 ? 12'hFFF : 12'h000);
            for (int i = 0; i < 3; i++) begin
                tick;
                check($sformatf("edge_slot%0d_hold%0d", s, i), pixon, s >= 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
